// File: rtl/rr_arb_client.sv
// rr_arb_client: clocked requestor bank for the async round-robin arbiter.
// Each channel runs a 4-phase request/grant handshake against a grant line
// that is synchronised locally before the channel FSM looks at it.
// Optional mutual-exclusion / spurious-grant checker: RR_ARB_CLIENT_MUTEX_CHECK_EN
// (when undefined, err is tied low and no checker logic exists).
//
// Handshake (4-phase, per channel i): request[i] rises and stays high until
// the synchronised grant gs[i] has been seen and the hold time has elapsed;
// request[i] then falls, and the channel waits for gs[i] to fall before it
// returns to IDLE and pulses done[i]. request never falls before gs rose, and
// never rises again before gs fell.
module rr_arb_client #(
    parameter int REQUESTORS  = 4,
    parameter int SYNC_STAGES = 2,  // must be at least 2
    parameter int HOLD_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REQUESTORS-1:0] start,
    input  logic [HOLD_W-1:0]     hold_cycles,
    output logic [REQUESTORS-1:0] request,
    input  logic [REQUESTORS-1:0] grant,
    output logic [REQUESTORS-1:0] busy,
    output logic [REQUESTORS-1:0] done,
    output logic                  err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    // Per-channel state is kept in a named array so checkers can bind to it.
    state_e                state_q [REQUESTORS];
    state_e                state_d [REQUESTORS];
    logic [HOLD_W-1:0]     cnt_q   [REQUESTORS];
    logic [HOLD_W-1:0]     cnt_d   [REQUESTORS];
    logic [REQUESTORS-1:0] request_q, request_d;
    logic [REQUESTORS-1:0] done_q, done_d;
    logic [REQUESTORS-1:0] sync_q  [SYNC_STAGES];
    logic [REQUESTORS-1:0] sync_d  [SYNC_STAGES];
    logic [REQUESTORS-1:0] gs;

    // Grant synchroniser: stage 0 samples the async grant, last stage is gs.
    always_comb begin
        sync_d[0] = grant;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign gs = sync_q[SYNC_STAGES-1];

    // Channel FSMs: independent 4-phase handshakes driven only by gs.
    always_comb begin
        request_d = request_q;
        done_d    = '0;
        for (int i = 0; i < REQUESTORS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (start[i]) begin
                        state_d[i]   = ST_REQ;
                        request_d[i] = 1'b1;
                        cnt_d[i]     = hold_cycles;
                    end
                end
                ST_REQ: begin
                    if (gs[i]) begin
                        state_d[i] = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // cnt counts down to zero, so HOLD lasts hold_cycles+1 clocks
                    if (cnt_q[i] == '0) begin
                        state_d[i]   = ST_RELEASE;
                        request_d[i] = 1'b0;
                    end else begin
                        cnt_d[i] = cnt_q[i] - HOLD_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!gs[i]) begin
                        state_d[i] = ST_IDLE;
                        done_d[i]  = 1'b1;
                    end
                end
                default: begin
                    state_d[i]   = ST_IDLE;
                    request_d[i] = 1'b0;
                end
            endcase
        end
    end

    // State, counters, outputs and synchroniser; reset drops request at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            request_q <= '0;
            done_q    <= '0;
            for (int i = 0; i < REQUESTORS; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            request_q <= request_d;
            done_q    <= done_d;
            for (int i = 0; i < REQUESTORS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
        end
    end

    // busy is decoded from the registered state of each channel.
    always_comb begin
        busy = '0;
        for (int i = 0; i < REQUESTORS; i++) begin
            busy[i] = (state_q[i] != ST_IDLE);
        end
    end

    assign request = request_q;
    assign done    = done_q;

`ifdef RR_ARB_CLIENT_MUTEX_CHECK_EN
    logic err_q, err_d;
    logic multi_gnt, spurious_gnt;

    // Sticky flag: two grants at once, or a grant to a channel that is idle.
    always_comb begin
        multi_gnt    = (gs & (gs - REQUESTORS'(1))) != '0;
        spurious_gnt = |(gs & ~busy);
        err_d        = err_q | multi_gnt | spurious_gnt;
    end

    // Checker flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb_client.sv
// tb_rr_arb_client: bench for rr_arb_client with a behavioural round-robin
// arbiter, a port-level channel model and a hold-length scoreboard.
module tb_rr_arb_client;

    localparam int N  = 4;
    localparam int HW = 4;
`ifdef RR_ARB_CLIENT_MUTEX_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  start = '0;
    logic [HW-1:0] hold_cycles = '0;
    logic [N-1:0]  request, grant, busy, done;
    logic          err;

    logic          arb_en = 1'b1;
    logic [N-1:0]  arb_grant = '0;
    logic [N-1:0]  force_grant = '0;

    assign grant = arb_en ? arb_grant : force_grant;

    rr_arb_client #(.REQUESTORS(N), .SYNC_STAGES(2), .HOLD_W(HW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .hold_cycles (hold_cycles),
        .request     (request),
        .grant       (grant),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural async arbiter ----------------
    // Updates 2 time units after the falling edge, well away from clk rise.
    int arb_last = N - 1;
    int arb_cur  = -1;
    int arb_c;
    always @(negedge clk) begin
        #2;
        if (!rst_n || !arb_en) begin
            arb_grant = '0;
            arb_cur   = -1;
        end else if (arb_cur >= 0) begin
            if (!request[arb_cur]) begin
                arb_grant = '0;
                arb_cur   = -1;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                arb_c = (arb_last + k) % N;
                if (arb_cur < 0 && request[arb_c]) arb_cur = arb_c;
            end
            if (arb_cur >= 0) begin
                arb_grant = N'(1) << arb_cur;
                arb_last  = arb_cur;
            end
        end
    end

    // ---------------- channel model and scoreboard ----------------
    // ph: 0 idle, 1 requesting/holding, 2 released (waiting for grant low).
    logic [1:0]   ph [N];
    int           hcnt [N];
    logic [N-1:0] s1 = '0, s2 = '0, gs_b = '0, gs_p = '0;
    logic         err_m = 1'b0;
    logic         exp_done;
    int           n_acc = 0, n_done = 0;
    int           idx;
    logic [15:0]  exp_q[$];   // {channel, expected HOLD cycles}

    function automatic logic [N-1:0] model_busy();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (ph[i] != 2'd0);
        return v;
    endfunction

    // Observes at the falling edge; inputs seen here are those sampled at
    // the preceding rising edge, since drivers change them only after it.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_request", request, '0);
            chk("rst_busy", busy, '0);
            chk("rst_done", done, '0);
            chk("rst_err", err, 1'b0);
            for (int i = 0; i < N; i++) begin
                ph[i]   = 2'd0;
                hcnt[i] = 0;
            end
            s1 = '0; s2 = '0; gs_b = '0; gs_p = '0;
            err_m = 1'b0;
            exp_q.delete();
        end else begin
            gs_p = gs_b;
            s2   = s1;
            s1   = grant;
            gs_b = s2;
            if ($countones(gs_p) > 1) err_m = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (gs_p[i] && ph[i] == 2'd0) err_m = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                exp_done = (ph[i] == 2'd2) && !gs_p[i];
                case (ph[i])
                    2'd0: begin
                        if (start[i]) begin
                            ph[i]   = 2'd1;
                            hcnt[i] = 0;
                            n_acc++;
                            exp_q.push_back({8'(i), 8'(hold_cycles) + 8'd1});
                            chk($sformatf("req_rise[%0d]", i), request[i], 1'b1);
                        end else begin
                            chk($sformatf("req_idle[%0d]", i), request[i], 1'b0);
                        end
                    end
                    2'd1: begin
                        if (request[i]) begin
                            if (gs_p[i]) hcnt[i]++;
                        end else begin
                            idx = -1;
                            for (int k = 0; k < exp_q.size(); k++) begin
                                if (idx < 0 && exp_q[k][15:8] == 8'(i)) idx = k;
                            end
                            if (idx >= 0) begin
                                chk($sformatf("hold_len[%0d]", i), 32'(hcnt[i]), 32'(exp_q[idx][7:0]));
                                exp_q.delete(idx);
                            end
                            ph[i] = 2'd2;
                        end
                    end
                    default: begin
                        chk($sformatf("req_release[%0d]", i), request[i], 1'b0);
                        if (exp_done) ph[i] = 2'd0;
                    end
                endcase
                if (done[i]) n_done++;
                chk($sformatf("done[%0d]", i), done[i], exp_done);
                chk($sformatf("busy[%0d]", i), busy[i], (ph[i] != 2'd0));
            end
            chk("err", err, CHK_EN ? err_m : 1'b0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_inputs(input logic [N-1:0] s, input logic [HW-1:0] h);
        @(negedge clk); #1;
        start       = s;
        hold_cycles = h;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic clear_counts();
        n_acc  = 0;
        n_done = 0;
    endtask

    task automatic wait_quiet(input int budget);
        int k;
        k = 0;
        @(negedge clk); #1;
        while ((model_busy() != '0 || exp_q.size() != 0 || grant != '0) && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        if (k >= budget) chk("wait_quiet_timeout", 32'(model_busy()), 32'(0));
        chk("quiet_busy", busy, '0);
        chk("quiet_request", request, '0);
        chk("done_count", n_done, n_acc);
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk); #1;
        rst_n = 1'b0;
        idle_cycles(n);
        rst_n = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        int k;

        // 1. reset with start toggling; no request without start afterwards
        rst_n = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            start = N'($urandom_range(0, 15));
        end
        start = '0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(5);
        chk("post_reset_request", request, '0);
        chk("post_reset_busy", busy, '0);

        // 2. single handshake, hold 3
        clear_counts();
        set_inputs(4'b0001, 4'd3);
        set_inputs(4'b0000, 4'd3);
        wait_quiet(100);

        // 3. contention, hold 2
        clear_counts();
        set_inputs(4'b0011, 4'd2);
        set_inputs(4'b0000, 4'd2);
        wait_quiet(150);

        // 4. minimum hold, back-to-back, hold change during HOLD
        clear_counts();
        set_inputs(4'b0100, 4'd0);
        k = 0;
        while (hcnt[2] == 0 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        if (k >= 50) chk("wait_hold2", hcnt[2], 1);
        hold_cycles = 4'd5;
        k = 0;
        while (n_done < 3 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        if (k >= 200) chk("wait_done2", n_done, 3);
        start = '0;
        wait_quiet(100);

        // random traffic
        clear_counts();
        for (int it = 0; it < 40; it++) begin
            set_inputs(N'($urandom_range(0, 15)), HW'($urandom_range(0, 7)));
            set_inputs('0, hold_cycles);
            idle_cycles($urandom_range(0, 6));
        end
        wait_quiet(600);

        // 5. reset asserted between edges while channel 1 is in HOLD
        set_inputs(4'b0010, 4'd6);
        set_inputs(4'b0000, 4'd6);
        k = 0;
        while (hcnt[1] < 2 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        if (k >= 50) chk("wait_hold1", hcnt[1], 2);
        chk("pre_reset_request1", request[1], 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_request1", request[1], 1'b0);
        chk("async_busy1", busy[1], 1'b0);
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(3);
        chk("after_reset_busy", busy, '0);

        // 6. checker: grant driven directly by the bench
        arb_en = 1'b0;
        @(negedge clk); #1;
        force_grant = 4'b0011;
        idle_cycles(1);
        force_grant = 4'b0000;
        idle_cycles(5);
        chk("err_multi_sticky", err, CHK_EN);
        pulse_reset(2);
        idle_cycles(2);
        chk("err_cleared", err, 1'b0);
        force_grant = 4'b0100;
        idle_cycles(2);
        force_grant = 4'b0000;
        idle_cycles(5);
        chk("err_spurious", err, CHK_EN);
        pulse_reset(2);
        arb_en = 1'b1;
        idle_cycles(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
